// File: rtl/sw_debounce_pkg.sv
// Shared types and constants for the switch debouncer.
// The SW_DEBOUNCE_TOGGLE_EN build option is handled in sw_debounce.sv.
package sw_debounce_pkg;

    localparam int CLK_HZ      = 50_000_000;
    localparam int DEBOUNCE_MS = 10;

    // Default settle time in clock cycles (500000 at 50 MHz and 10 ms).
    localparam int STABLE_CYCLES_DEFAULT = (CLK_HZ / 1000) * DEBOUNCE_MS;

    typedef enum logic [1:0] {
        S_LOW     = 2'd0,
        S_WAIT_HI = 2'd1,
        S_HIGH    = 2'd2,
        S_WAIT_LO = 2'd3
    } state_t;

endpackage

// File: rtl/sync_ff.sv
// Multi-stage flop synchroniser that brings an asynchronous level into the
// iCLK domain. Reusable for any board input.
module sync_ff #(
    parameter int SYNC_STAGES = 2
) (
    input  logic iCLK,
    input  logic iRST,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] chain;

    // Plain shift chain with no logic between stages, so metastability can
    // resolve before the last stage is used.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            chain <= '0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], d};
        end
    end

    assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/sw_debounce.sv
// Switch debouncer: synchroniser, stability counter FSM, and registered edge pulses.
// Define SW_DEBOUNCE_TOGGLE_EN to add the oTOGGLE press-to-toggle output.
module sw_debounce
    import sw_debounce_pkg::*;
#(
    parameter int STABLE_CYCLES = STABLE_CYCLES_DEFAULT,
    parameter int SYNC_STAGES   = 2
) (
    input  logic iCLK,
    input  logic iRST,
    input  logic iSW,
    output logic oSW,
    output logic oRISE,
    output logic oFALL
`ifdef SW_DEBOUNCE_TOGGLE_EN
    ,
    output logic oTOGGLE
`endif
);

    localparam int CNT_W = $clog2(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             sw_s;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sw_q, sw_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;

    sync_ff #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .iCLK (iCLK),
        .iRST (iRST),
        .d    (iSW),
        .q    (sw_s)
    );

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q <= S_LOW;
            cnt_q   <= '0;
            sw_q    <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sw_q    <= sw_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    // The counter measures how long sw_s has disagreed with the debounced
    // level; any agreeing sample drops straight back to the settled state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sw_d    = sw_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        case (state_q)
            S_LOW: begin
                sw_d  = 1'b0;
                cnt_d = '0;
                if (sw_s) begin
                    state_d = S_WAIT_HI;
                    cnt_d   = CNT_ONE;
                end
            end
            S_WAIT_HI: begin
                sw_d = 1'b0;
                if (!sw_s) begin
                    state_d = S_LOW;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_HIGH;
                    sw_d    = 1'b1;
                    rise_d  = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_HIGH: begin
                sw_d  = 1'b1;
                cnt_d = '0;
                if (!sw_s) begin
                    state_d = S_WAIT_LO;
                    cnt_d   = CNT_ONE;
                end
            end
            S_WAIT_LO: begin
                sw_d = 1'b1;
                if (sw_s) begin
                    state_d = S_HIGH;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_LOW;
                    sw_d    = 1'b0;
                    fall_d  = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = S_LOW;
                cnt_d   = '0;
                sw_d    = 1'b0;
            end
        endcase
    end

    assign oSW   = sw_q;
    assign oRISE = rise_q;
    assign oFALL = fall_q;

`ifdef SW_DEBOUNCE_TOGGLE_EN
    logic toggle_q;

    // Flips one cycle after each registered rise pulse.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            toggle_q <= 1'b0;
        end else if (rise_q) begin
            toggle_q <= ~toggle_q;
        end
    end

    assign oTOGGLE = toggle_q;
`endif

endmodule

// File: doc/sw_debounce.md
Name: sw_debounce

Overview:
- Input-conditioning stage placed directly upstream of the Lab2 LED logic.
- Takes the raw asynchronous board switch/button iSW and synchronises it into the iCLK domain (50 MHz).
- Filters contact bounce and delivers a clean level plus single-cycle edge pulses, which the LED stage consumes instead of raw iSW.

Parameters:
- STABLE_CYCLES, 500000, cycles the synchronised input must differ from oSW before oSW flips (10 ms at 50 MHz); legal range ≥ 2.
- SYNC_STAGES, 2, synchroniser flop depth; legal range ≥ 2.

Ports:
- iCLK  input  1  system clock, 50 MHz, all logic on rising edge
- iRST  input  1  synchronous, active-high reset
- iSW   input  1  raw asynchronous switch level
- oSW   output 1  debounced, synchronised switch level
- oRISE output 1  one-cycle pulse on debounced 0→1
- oFALL output 1  one-cycle pulse on debounced 1→0

Behaviour:
- Reset (iRST high at a rising edge of iCLK): synchroniser flops, counter, oSW, oRISE and oFALL all go to 0. Reset takes priority over every other event.
- Synchroniser: SYNC_STAGES flop chain. sw_s is the last stage. No logic between stages.
- Counter width: CNT_W = $clog2(STABLE_CYCLES). The counter never exceeds STABLE_CYCLES-1.
- FSM, 4 states, encoded in a shared package:
  - S_LOW: oSW=0, cnt=0. If sw_s=1, go to S_WAIT_HI with cnt=1.
  - S_WAIT_HI: oSW=0.
    - If sw_s=0, go to S_LOW with cnt=0 (bounce rejected).
    - Else if cnt==STABLE_CYCLES-1, go to S_HIGH: oSW←1, oRISE←1 for that cycle, cnt←0.
    - Else cnt←cnt+1.
  - S_HIGH: mirror of S_LOW, with oSW=1 and entry to S_WAIT_LO on sw_s=0.
  - S_WAIT_LO: mirror of S_WAIT_HI, with exit to S_LOW: oSW←0, oFALL←1.
- Latency: a clean iSW step held steady appears on oSW exactly SYNC_STAGES+STABLE_CYCLES rising edges later. oRISE/oFALL are asserted in the first cycle oSW shows the new value.
- Glitch rejection: any pulse on sw_s shorter than STABLE_CYCLES cycles produces no change on oSW and no pulse.
- Pulses: oRISE and oFALL are registered, last exactly 1 cycle, and are never high together.
- Reset mid-count: the pending transition is discarded and the FSM restarts in S_LOW.
- iSW high at reset release: treated as a normal press, so oRISE fires SYNC_STAGES+STABLE_CYCLES cycles after release.
- Illegal FSM state: default branch returns to S_LOW with oSW=0.
- All outputs are driven by flops; no combinational path from iSW to any output.

Optional Feature:
- Macro: SW_DEBOUNCE_TOGGLE_EN.
- Defined:
  - Adds output port oTOGGLE (1 bit), reset value 0.
  - oTOGGLE inverts on the cycle after each oRISE pulse, giving a press-to-toggle LED source.
  - oFALL has no effect on it.
- Undefined: port and flop are absent, and the remaining behaviour is identical.

Decomposition:
- Package sw_debounce_pkg holds:
  - FSM state typedef (S_LOW, S_WAIT_HI, S_HIGH, S_WAIT_LO)
  - constant CLK_HZ = 50_000_000
  - default DEBOUNCE_MS = 10, from which the STABLE_CYCLES default is derived
- One natural sub-module: sync_ff.
  - Parameterised SYNC_STAGES-deep flop chain with iCLK/iRST.
  - Reused later for any other board input.
- The FSM, counter and pulse logic stay in sw_debounce.

Test Plan (override STABLE_CYCLES=8, SYNC_STAGES=2; iCLK period 20 ns):
- Reset with iSW=1: hold iRST 3 cycles → oSW/oRISE/oFALL=0 throughout; after release, oRISE pulses once and oSW=1 exactly 10 cycles after release.
- Clean press/release: iSW 0→1 held 20 cycles, then 1→0 held 20 cycles → oSW rises 10 cycles after the first edge with one oRISE; falls 10 cycles after the second edge with one oFALL.
- Bounce: iSW toggles every 3 cycles for 30 cycles, then holds 1 → no pulses during bounce; exactly one oRISE 10 cycles after the last edge.
- Glitch: single 7-cycle high pulse on iSW from steady 0 → oSW stays 0, no oRISE/oFALL.
- Reset mid-count: iSW 0→1, assert iRST 5 cycles later for 1 cycle, iSW held at 1 → outputs 0 during reset; oRISE arrives 10 cycles after iRST deasserts, not earlier.
- SW_DEBOUNCE_TOGGLE_EN defined: two clean press/release cycles → oTOGGLE 0→1 one cycle after the first oRISE, 1→0 one cycle after the second; unchanged on each oFALL.
